// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply processing elements.
//   pe_state_t : processing-element control state (IDLE, MAC, OUTPUT)
//   idx_w(x)   : width of an index that counts 0..x-1 (at least 1 bit)
//   acc_w(dw,k): accumulator width that holds a k-term sum of dw x dw
//                signed products without overflow
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    OUTPUT = 2'd2
  } pe_state_t;

  function automatic int idx_w(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  function automatic int acc_w(input int dw, input int k);
    return 2 * dw + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/pe_dot_engine_mac_unit.sv
// mac_unit: one signed DW x DW multiplier feeding an AW-bit accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : load zero into the accumulator (wins over en)
//   en         : add the current product into the accumulator
//   a, b       : signed operands
//   acc        : registered accumulator value
//   sum        : acc + sext(a*b), the value acc takes on an enabled edge
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DW = 8,
  parameter int K  = 4,
  localparam int AW = acc_w(DW, K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc,
  output logic [AW-1:0] sum
);

  logic signed [2*DW-1:0] prod;
  logic        [AW-1:0]   prod_ext;

  assign prod     = $signed(a) * $signed(b);
  // AW is always wider than the product, so the replication is never empty.
  assign prod_ext = {{(AW - 2*DW){prod[2*DW-1]}}, prod};
  assign sum      = acc + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/pe_dot_engine.sv
// pe_dot_engine: captures a row and a column vector on an issue pulse,
// runs a K-cycle signed multiply-accumulate and offers the dot product on a
// valid/ready port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_PE            : one-cycle issue pulse
//   row_data, col_data  : K packed signed DW-bit elements, element k at [k*DW +: DW]
//   n_in, m_in          : job tags carried through to the result
//   PE_ready            : high only while idle; an issue is accepted
//   res_valid/res_ready : result handshake
//   res_data, res_n/m   : signed dot product and its tags
//   issue_err           : sticky, an issue arrived while not ready
module pe_dot_engine
  import matmul_pkg::*;
#(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int K  = 4,
  parameter int DW = 8,
  localparam int NW = idx_w(N),
  localparam int MW = idx_w(M),
  localparam int KW = idx_w(K),
  localparam int AW = acc_w(DW, K)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_PE,
  input  logic [K*DW-1:0] row_data,
  input  logic [K*DW-1:0] col_data,
  input  logic [NW-1:0]   n_in,
  input  logic [MW-1:0]   m_in,
  output logic            PE_ready,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [AW-1:0]   res_data,
  output logic [NW-1:0]   res_n,
  output logic [MW-1:0]   res_m,
  output logic            issue_err
);

  pe_state_t state_reg, state_next;

  logic [KW-1:0]   k_reg;
  logic [K*DW-1:0] row_reg, col_reg;
  logic [NW-1:0]   tag_n_reg;
  logic [MW-1:0]   tag_m_reg;

  logic [DW-1:0] row_elem [K];
  logic [DW-1:0] col_elem [K];

  logic          issue_ok;
  logic          mac_en;
  logic          last_mac;
  logic          handshake;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;

  // Unpack the captured operand vectors so the k counter can select a lane.
  for (genvar gi = 0; gi < K; gi++) begin : g_unpack
    assign row_elem[gi] = row_reg[gi*DW +: DW];
    assign col_elem[gi] = col_reg[gi*DW +: DW];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_PE)  state_next = MAC;
      MAC:     if (last_mac)  state_next = OUTPUT;
      OUTPUT:  if (res_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / strobes ----------------
  always_comb begin
    PE_ready  = (state_reg == IDLE);
    res_valid = (state_reg == OUTPUT);
    mac_en    = (state_reg == MAC);
    issue_ok  = PE_ready && start_PE;
    // k never counts past K-1, so this is the last product of the job.
    last_mac  = mac_en && (k_reg == KW'(K - 1));
    handshake = res_valid && res_ready;
  end

  mac_unit #(
    .DW (DW),
    .K  (K)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (issue_ok),
    .en    (mac_en),
    .a     (row_elem[k_reg]),
    .b     (col_elem[k_reg]),
    .acc   (acc),
    .sum   (acc_sum)
  );

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg     <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      tag_n_reg <= '0;
      tag_m_reg <= '0;
      res_data  <= '0;
      res_n     <= '0;
      res_m     <= '0;
      issue_err <= 1'b0;
    end else begin
      if (issue_ok) begin
        row_reg   <= row_data;
        col_reg   <= col_data;
        tag_n_reg <= n_in;
        tag_m_reg <= m_in;
        k_reg     <= '0;
      end else if (mac_en && !last_mac) begin
        k_reg <= k_reg + KW'(1);
      end

      // The final product is folded in here rather than waiting a cycle for
      // acc, which keeps res_valid at K+1 cycles after the issue.
      if (last_mac) begin
        res_data <= acc_sum;
        res_n    <= tag_n_reg;
        res_m    <= tag_m_reg;
      end

      // Any issue outside IDLE is dropped, including one that coincides
      // with the result handshake.
      if (start_PE && !PE_ready) begin
        issue_err <= 1'b1;
      end
    end
  end

endmodule
